systolic_acc_buffer: RTL and testbench

//   Accumulator storage directly downstream of the systolic array controller.

---
 rtl/systolic_acc_buffer.sv | 147 ++++++++++++++
 tb/tb_systolic_acc_buffer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_acc_buffer.sv
// Accumulator buffer behind the 3x3 systolic array.
// Sequences column psums into entries; 1-cycle commit, registered read.
module systolic_acc_buffer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              acc_wr_en,
   input  logic [ADDR_W-1:0] acc_wr_addr,
   input  logic              acc_wr_col01,
   input  logic              acc_wr_col2,
   input  logic              acc_clear,
   input  logic              acc_mode,
   input  logic [DATA_W-1:0] col_psum0,
   input  logic [DATA_W-1:0] col_psum1,
   input  logic [DATA_W-1:0] col_psum2,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              sat_flag,
   output logic              seq_err
);

   typedef enum logic [1:0] {COL0, COL1, COL2} col_e;

   col_e              col_q, col_d;
   logic              s1_vld_q;
   logic [ADDR_W-1:0] s1_addr_q;
   logic [DATA_W-1:0] s1_data_q;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  vld_q;

   logic              wr_ok, wr_err;
   logic [DATA_W-1:0] wr_data;

   always_comb begin
      wr_ok   = 1'b0;
      wr_err  = 1'b0;
      wr_data = col_psum0;
      col_d   = col_q;
      if (acc_wr_en) begin
         if (acc_wr_col01 == acc_wr_col2) begin
            wr_err = 1'b1;
         end else if (acc_wr_col2) begin
            wr_ok   = 1'b1;
            wr_data = col_psum2;
            col_d   = COL0;
            wr_err  = (col_q != COL2);
         end else begin
            wr_ok = 1'b1;
            unique case (col_q)
               COL0: begin
                  wr_data = col_psum0;
                  col_d   = COL1;
               end
               COL1: begin
                  wr_data = col_psum1;
                  col_d   = COL2;
               end
               default: begin
                  // col01 out of order restarts the triple at column 0
                  wr_data = col_psum0;
                  col_d   = COL1;
                  wr_err  = 1'b1;
               end
            endcase
         end
      end
   end

   logic [DATA_W-1:0] old_val, sat_val, cm_data, rd_val;
   logic [DATA_W:0]   sum;
   logic              acc, ovf, commit, cm_sat, fwd;

   always_comb begin
      old_val = mem[s1_addr_q];
      acc     = acc_mode && vld_q[s1_addr_q];
      sum     = {old_val[DATA_W-1], old_val}
              + {s1_data_q[DATA_W-1], s1_data_q};
      ovf     = sum[DATA_W] ^ sum[DATA_W-1];
      if (!ovf)
         sat_val = sum[DATA_W-1:0];
      else if (sum[DATA_W])
         sat_val = {1'b1, {(DATA_W-1){1'b0}}};
      else
         sat_val = {1'b0, {(DATA_W-1){1'b1}}};
      commit  = s1_vld_q && !acc_clear;
      cm_data = acc ? sat_val : s1_data_q;
      cm_sat  = commit && acc && ovf;
      fwd     = commit && (s1_addr_q == rd_addr);
      if (fwd)
         rd_val = cm_data;
      else if (vld_q[rd_addr])
         rd_val = mem[rd_addr];
      else
         rd_val = '0;
   end

   always_ff @(posedge clk) begin
      if (commit)
         mem[s1_addr_q] <= cm_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q     <= COL0;
         s1_vld_q  <= 1'b0;
         s1_addr_q <= '0;
         s1_data_q <= '0;
         vld_q     <= '0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
         sat_flag  <= 1'b0;
         seq_err   <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (acc_clear) begin
            col_q    <= COL0;
            s1_vld_q <= 1'b0;
            vld_q    <= '0;
            sat_flag <= 1'b0;
            seq_err  <= acc_wr_en;
            if (rd_en)
               rd_data <= '0;
         end else begin
            col_q    <= col_d;
            s1_vld_q <= wr_ok;
            if (wr_ok) begin
               s1_addr_q <= acc_wr_addr;
               s1_data_q <= wr_data;
            end
            if (commit)
               vld_q[s1_addr_q] <= 1'b1;
            if (cm_sat)
               sat_flag <= 1'b1;
            if (wr_err)
               seq_err <= 1'b1;
            if (rd_en)
               rd_data <= rd_val;
         end
      end
   end

endmodule

// File: tb/tb_systolic_acc_buffer.sv
// Bench for systolic_acc_buffer: read results checked
// against a queue of expected values filled as reads are issued.
module tb_systolic_acc_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        acc_wr_en;
   logic [7:0]  acc_wr_addr;
   logic        acc_wr_col01;
   logic        acc_wr_col2;
   logic        acc_clear;
   logic        acc_mode;
   logic [31:0] col_psum0;
   logic [31:0] col_psum1;
   logic [31:0] col_psum2;
   logic        rd_en;
   logic [7:0]  rd_addr;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        sat_flag;
   logic        seq_err;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] sb [$];
   logic [31:0] exp_v;

   systolic_acc_buffer dut (
      .clk(clk), .rst_n(rst_n),
      .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr),
      .acc_wr_col01(acc_wr_col01), .acc_wr_col2(acc_wr_col2),
      .acc_clear(acc_clear), .acc_mode(acc_mode),
      .col_psum0(col_psum0), .col_psum1(col_psum1),
      .col_psum2(col_psum2),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .sat_flag(sat_flag), .seq_err(seq_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic c01, input logic c2);
      acc_wr_en    = 1'b1;
      acc_wr_addr  = a;
      acc_wr_col01 = c01;
      acc_wr_col2  = c2;
      tick();
      acc_wr_en    = 1'b0;
      acc_wr_col01 = 1'b0;
      acc_wr_col2  = 1'b0;
   endtask

   task automatic clr;
      acc_clear = 1'b1;
      tick();
      acc_clear = 1'b0;
   endtask

   task automatic drive_rd(input logic [7:0] a, input logic [31:0] e);
      rd_en   = 1'b1;
      rd_addr = a;
      sb.push_back(e);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      acc_wr_en = 0; acc_wr_addr = 0; acc_wr_col01 = 0; acc_wr_col2 = 0;
      acc_clear = 0; acc_mode = 0; rd_en = 0; rd_addr = 0;
      col_psum0 = 0; col_psum1 = 0; col_psum2 = 0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      n_checks += 4;
      if (rd_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid);
      end
      if (rd_data !== 32'h0) begin
         n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data);
      end
      if (sat_flag !== 1'b0) begin
         n_fail++; $display("FAIL reset_sat_flag: got %b want 0", sat_flag);
      end
      if (seq_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_seq_err: got %b want 0", seq_err);
      end
   endtask

   task automatic test_overwrite;
      acc_mode = 0;
      col_psum0 = 5; col_psum1 = 6; col_psum2 = 7;
      clr();
      wr(8'h10, 1, 0); wr(8'h11, 1, 0); wr(8'h12, 0, 1);
      for (int i = 0; i < 3; i++) begin
         drive_rd(8'h10 + 8'(i), 32'(5 + i));
         tick(); rd_en = 0;
         exp_v = sb.pop_front(); n_checks++;
         if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
            n_fail++;
            $display("FAIL overwrite[%0d]: got v=%b %h want %h", i, rd_valid, rd_data, exp_v);
         end
      end
      n_checks++;
      if (seq_err !== 1'b0) begin
         n_fail++; $display("FAIL overwrite_seq_err: got %b want 0", seq_err);
      end
   endtask

   task automatic test_accumulate;
      acc_mode = 1;
      col_psum0 = 1; col_psum1 = 2; col_psum2 = 3;
      wr(8'h10, 1, 0); wr(8'h11, 1, 0); wr(8'h12, 0, 1);
      for (int i = 0; i < 3; i++) begin
         drive_rd(8'h10 + 8'(i), 32'(6 + 2 * i));
         tick(); rd_en = 0;
         exp_v = sb.pop_front(); n_checks++;
         if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
            n_fail++;
            $display("FAIL accumulate[%0d]: got %h want %h", i, rd_data, exp_v);
         end
      end
   endtask

   task automatic test_saturate;
      clr();
      acc_mode = 0; col_psum0 = 32'h20;
      wr(8'h30, 1, 0);
      tick();
      acc_mode = 1; col_psum1 = 32'h7FFF_FFF0;
      wr(8'h30, 1, 0);
      drive_rd(8'h30, 32'h7FFF_FFFF);
      tick(); rd_en = 0;
      exp_v = sb.pop_front(); n_checks += 2;
      if (rd_data !== exp_v) begin
         n_fail++; $display("FAIL sat_pos: got %h want %h", rd_data, exp_v);
      end
      if (sat_flag !== 1'b1) begin
         n_fail++; $display("FAIL sat_pos_flag: got %b want 1", sat_flag);
      end
      clr();
      n_checks++;
      if (sat_flag !== 1'b0) begin
         n_fail++; $display("FAIL sat_clear: got %b want 0", sat_flag);
      end
      acc_mode = 0; col_psum0 = 32'h8000_0005;
      wr(8'h31, 1, 0);
      tick();
      acc_mode = 1; col_psum1 = 32'h8000_0000;
      wr(8'h31, 1, 0);
      drive_rd(8'h31, 32'h8000_0000);
      tick(); rd_en = 0;
      exp_v = sb.pop_front(); n_checks += 2;
      if (rd_data !== exp_v) begin
         n_fail++; $display("FAIL sat_neg: got %h want %h", rd_data, exp_v);
      end
      if (sat_flag !== 1'b1) begin
         n_fail++; $display("FAIL sat_neg_flag: got %b want 1", sat_flag);
      end
   endtask

   task automatic test_seq_err;
      clr();
      acc_mode = 0; col_psum0 = 32'h55; col_psum1 = 32'h66; col_psum2 = 32'h77;
      wr(8'h40, 0, 1);
      n_checks++;
      if (seq_err !== 1'b1) begin
         n_fail++; $display("FAIL seq_col2_in_col0: got %b want 1", seq_err);
      end
      wr(8'h41, 1, 0);
      for (int i = 0; i < 2; i++) begin
         drive_rd(8'h40 + 8'(i), (i == 0) ? 32'h77 : 32'h55);
         tick(); rd_en = 0;
         exp_v = sb.pop_front(); n_checks++;
         if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
            n_fail++; $display("FAIL seq_data[%0d]: got %h want %h", i, rd_data, exp_v);
         end
      end
      clr();
      n_checks++;
      if (seq_err !== 1'b0) begin
         n_fail++; $display("FAIL seq_clear: got %b want 0", seq_err);
      end
      wr(8'h42, 1, 1);
      n_checks++;
      if (seq_err !== 1'b1) begin
         n_fail++; $display("FAIL seq_both_strobes: got %b want 1", seq_err);
      end
      tick();
      drive_rd(8'h42, 32'h0);
      tick(); rd_en = 0;
      exp_v = sb.pop_front(); n_checks++;
      if (rd_data !== exp_v) begin
         n_fail++; $display("FAIL seq_dropped: got %h want %h", rd_data, exp_v);
      end
      acc_clear = 1;
      wr(8'h43, 1, 0);
      acc_clear = 0;
      n_checks++;
      if (seq_err !== 1'b1) begin
         n_fail++; $display("FAIL seq_wr_in_clear: got %b want 1", seq_err);
      end
      tick();
      drive_rd(8'h43, 32'h0);
      tick(); rd_en = 0;
      exp_v = sb.pop_front(); n_checks++;
      if (rd_data !== exp_v) begin
         n_fail++; $display("FAIL clear_wr_dropped: got %h want %h", rd_data, exp_v);
      end
   endtask

   task automatic test_forward;
      clr();
      acc_mode = 0; col_psum0 = 32'h123; col_psum1 = 32'h456;
      acc_wr_en = 1; acc_wr_addr = 8'h51; acc_wr_col01 = 1;
      drive_rd(8'h51, 32'h0);
      tick();
      acc_wr_en = 0; acc_wr_col01 = 0;
      exp_v = sb.pop_front(); n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
         n_fail++; $display("FAIL fwd_s1_excluded: got %h want %h", rd_data, exp_v);
      end
      drive_rd(8'h51, 32'h123);
      tick(); rd_en = 0;
      exp_v = sb.pop_front(); n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
         n_fail++; $display("FAIL fwd_commit: got %h want %h", rd_data, exp_v);
      end
   endtask

   task automatic test_back_to_back;
      clr();
      acc_mode = 1; col_psum0 = 10; col_psum1 = 20; col_psum2 = 30;
      wr(8'h60, 1, 0); wr(8'h60, 1, 0); wr(8'h60, 0, 1);
      drive_rd(8'h60, 32'd60);
      tick(); rd_en = 0;
      exp_v = sb.pop_front(); n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
         n_fail++; $display("FAIL b2b_accum: got %h want %h", rd_data, exp_v);
      end
   endtask

   task automatic test_clear_pending;
      acc_mode = 0; col_psum0 = 32'h99;
      wr(8'h70, 1, 0);
      acc_clear = 1;
      drive_rd(8'h70, 32'h0);
      tick();
      acc_clear = 0; rd_en = 0;
      exp_v = sb.pop_front(); n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
         n_fail++; $display("FAIL clr_rd_during: got %h want %h", rd_data, exp_v);
      end
      for (int i = 0; i < 2; i++) begin
         drive_rd((i == 0) ? 8'h70 : 8'h60, 32'h0);
         tick(); rd_en = 0;
         exp_v = sb.pop_front(); n_checks++;
         if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
            n_fail++; $display("FAIL clr_pending[%0d]: got %h want %h", i, rd_data, exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_overwrite();
      test_accumulate();
      test_saturate();
      test_seq_err();
      test_forward();
      test_back_to_back();
      test_clear_pending();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
